// File: rtl/clk_period_meas.sv
// rtl/clk_period_meas.sv - half-period meter for an async square wave; optional duty outputs via CLK_PERIOD_MEAS_DUTY_EN
module clk_period_meas #(
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 1000,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
`ifdef CLK_PERIOD_MEAS_DUTY_EN
    ,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time
`endif
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [MW-1:0]    LOCK_C    = MW'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, MEAS, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             dly_q, dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic [MW-1:0]    match_q, match_d;
    logic [CNT_W-1:0] half_period_q, half_period_d;
    logic             period_valid_q, period_valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
`ifdef CLK_PERIOD_MEAS_DUTY_EN
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [CNT_W-1:0] low_time_q, low_time_d;
`endif

    logic             edge_det;
    logic [CNT_W-1:0] diff;
    logic             is_match;
    logic [MW-1:0]    match_inc;

    assign edge_det  = sync2_q ^ dly_q;
    assign diff      = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);
    assign is_match  = have_prev_q && (diff <= TOL_C);
    assign match_inc = match_q + MW'(1);

    // Next-state: synchronizer, interval counter, measurement/lock FSM, timeout
    always_comb begin
        state_d        = state_q;
        sync1_d        = sig_in;
        sync2_d        = sync1_q;
        dly_d          = sync2_q;
        prev_d         = prev_q;
        have_prev_d    = have_prev_q;
        match_d        = match_q;
        half_period_d  = half_period_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        timeout_d      = 1'b0;
`ifdef CLK_PERIOD_MEAS_DUTY_EN
        high_time_d    = high_time_q;
        low_time_d     = low_time_q;
`endif
        if (edge_det) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                // First interval after leaving IDLE is partial, so nothing is reported
                if (edge_det) begin
                    state_d     = MEAS;
                    have_prev_d = 1'b0;
                    match_d     = '0;
                    locked_d    = 1'b0;
                end
            end
            MEAS, LOCKED: begin
                if (edge_det) begin
                    half_period_d  = cnt_q;
                    period_valid_d = 1'b1;
                    prev_d         = cnt_q;
                    have_prev_d    = 1'b1;
`ifdef CLK_PERIOD_MEAS_DUTY_EN
                    if (dly_q && !sync2_q) begin
                        high_time_d = cnt_q;
                    end else begin
                        low_time_d = cnt_q;
                    end
`endif
                    if (is_match) begin
                        if (state_q == MEAS) begin
                            match_d = match_inc;
                            if (match_inc == LOCK_C) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end
                    end else begin
                        match_d  = '0;
                        state_d  = MEAS;
                        locked_d = 1'b0;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_d   = 1'b1;
                    locked_d    = 1'b0;
                    match_d     = '0;
                    have_prev_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            dly_q          <= 1'b0;
            cnt_q          <= '0;
            prev_q         <= '0;
            have_prev_q    <= 1'b0;
            match_q        <= '0;
            half_period_q  <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
`ifdef CLK_PERIOD_MEAS_DUTY_EN
            high_time_q    <= '0;
            low_time_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            dly_q          <= dly_d;
            cnt_q          <= cnt_d;
            prev_q         <= prev_d;
            have_prev_q    <= have_prev_d;
            match_q        <= match_d;
            half_period_q  <= half_period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
`ifdef CLK_PERIOD_MEAS_DUTY_EN
            high_time_q    <= high_time_d;
            low_time_q     <= low_time_d;
`endif
        end
    end

    assign half_period  = half_period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;
`ifdef CLK_PERIOD_MEAS_DUTY_EN
    assign high_time    = high_time_q;
    assign low_time     = low_time_q;
`endif

endmodule

// File: tb/tb_clk_period_meas.sv
// tb/tb_clk_period_meas.sv - directed self-checking bench for clk_period_meas
module tb_clk_period_meas;

    logic        clk = 1'b0;
    logic        reset;
    logic        sig_in;
    logic [15:0] half_period;
    logic        period_valid;
    logic        locked;
    logic        timeout;
`ifdef CLK_PERIOD_MEAS_DUTY_EN
    logic [15:0] high_time;
    logic [15:0] low_time;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int to_cnt = 0;
    int to_cyc = 0;
    int to_locked = 0;
    int last_pv = 0;
    int bad = 0;
    int hp_log[$];
    int lk_log[$];
    int pv_cyc[$];

    clk_period_meas dut (
        .clk          (clk),
        .reset        (reset),
        .sig_in       (sig_in),
        .half_period  (half_period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
`ifdef CLK_PERIOD_MEAS_DUTY_EN
        ,
        .high_time    (high_time),
        .low_time     (low_time)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (period_valid === 1'b1) begin
            hp_log.push_back(int'(half_period));
            lk_log.push_back(int'(locked));
            pv_cyc.push_back(cyc);
        end
        if (timeout === 1'b1) begin
            to_cnt++;
            to_cyc    = cyc;
            to_locked = int'(locked);
        end
    endtask

    task automatic toggle_run(input int k);
        sig_in = ~sig_in;
        repeat (k) step();
    endtask

    task automatic clear_logs();
        hp_log.delete();
        lk_log.delete();
        pv_cyc.delete();
        to_cnt = 0;
    endtask

    task automatic pulse_reset();
        reset  = 1'b0;
        sig_in = 1'b0;
        #1;
        chk("rst_async_hp", half_period, 0);
        chk("rst_async_pv", period_valid, 0);
        chk("rst_async_lk", locked, 0);
        chk("rst_async_to", timeout, 0);
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        sig_in = 1'b0;
        repeat (20) step();
        chk("reset_hp", half_period, 0);
        chk("reset_pv", period_valid, 0);
        chk("reset_lk", locked, 0);
        chk("reset_to", timeout, 0);

        // Idle with static input must never time out
        reset = 1'b1;
        clear_logs();
        repeat (1500) step();
        chk("idle_no_timeout", to_cnt, 0);
        chk("idle_no_strobe", hp_log.size(), 0);

        // Steady 6-cycle toggling
        clear_logs();
        repeat (12) toggle_run(6);
        chk("steady_strobes", hp_log.size(), 11);
        bad = 0;
        foreach (hp_log[i]) if (hp_log[i] != 6) bad++;
        chk("steady_hp_all6", bad, 0);
        bad = 0;
        for (int i = 1; i < pv_cyc.size(); i++) if (pv_cyc[i] - pv_cyc[i-1] != 6) bad++;
        chk("steady_spacing", bad, 0);
        chk("steady_lk_m4", lk_log[3], 0);
        chk("steady_lk_m5", lk_log[4], 1);
        chk("steady_lk_last", lk_log[10], 1);

        // One 9-cycle interval while locked
        clear_logs();
        toggle_run(9);
        repeat (7) toggle_run(6);
        chk("glitch_strobes", hp_log.size(), 8);
        chk("glitch_pre_lk", lk_log[0], 1);
        chk("glitch_hp9", hp_log[1], 9);
        chk("glitch_lk_drop", lk_log[1], 0);
        chk("glitch_lk_4after", lk_log[5], 0);
        chk("glitch_lk_relock", lk_log[6], 1);
        last_pv = pv_cyc[pv_cyc.size()-1];

        // Stop toggling while locked
        clear_logs();
        repeat (1100) step();
        chk("to_count", to_cnt, 1);
        chk("to_delay", to_cyc - last_pv, 1000);
        chk("to_locked", to_locked, 0);
        chk("to_hp_hold", half_period, 6);
        chk("to_no_strobe", hp_log.size(), 0);

        // Edge coinciding with cnt==TIMEOUT wins; one cycle longer times out
        clear_logs();
        toggle_run(6);
        toggle_run(1000);
        toggle_run(6);
        toggle_run(1001);
        toggle_run(6);
        chk("bnd_strobes", hp_log.size(), 3);
        chk("bnd_hp1000", hp_log[1], 1000);
        chk("bnd_to_count", to_cnt, 1);
        chk("bnd_to_delay", to_cyc - pv_cyc[2], 1000);

        // Alternating 6/7 intervals lock within tolerance
        clear_logs();
        repeat (6) begin
            toggle_run(7);
            toggle_run(6);
        end
        chk("alt_strobes", hp_log.size(), 12);
        chk("alt_hp1", hp_log[1], 7);
        chk("alt_hp2", hp_log[2], 6);
        chk("alt_lk_m4", lk_log[3], 0);
        bad = 0;
        for (int i = 4; i < lk_log.size(); i++) if (lk_log[i] != 1) bad++;
        chk("alt_lk_held", bad, 0);
        chk("alt_lk_now", locked, 1);

        // One-cycle reset while locked
        pulse_reset();
        chk("rst_pulse_lk", locked, 0);
        clear_logs();
        repeat (8) toggle_run(6);
        chk("relock_strobes", hp_log.size(), 7);
        chk("relock_lk_m4", lk_log[3], 0);
        chk("relock_lk_m5", lk_log[4], 1);

`ifdef CLK_PERIOD_MEAS_DUTY_EN
        // High 4 / low 8 duty cycle
        pulse_reset();
        clear_logs();
        repeat (5) begin
            toggle_run(4);
            toggle_run(8);
        end
        chk("duty_high", high_time, 4);
        chk("duty_low", low_time, 8);
        chk("duty_hp0", hp_log[0], 4);
        chk("duty_hp1", hp_log[1], 8);
        bad = 0;
        foreach (lk_log[i]) if (lk_log[i] != 0) bad++;
        chk("duty_never_lock", bad, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
